// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment patterns, digit indices and scan FSM states
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic DIG_UNITS = 1'b0;
    localparam logic DIG_TENS  = 1'b1;

    typedef enum logic {WAIT_U, WAIT_T} scan_state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - active-low 7-segment pattern to BCD digit decoder
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    input  logic       is_tens,
    output logic [3:0] bcd,
    output logic       illegal
);

    always_comb begin
        bcd     = 4'd0;
        illegal = 1'b0;
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            // leading-zero blanking is only meaningful on the tens digit
            SEG_BLANK: illegal = ~is_tens;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - reconstructs a stable two-digit value from sampled HEX0/HEX1 segments
module seven_seg_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_SCANS = 3,
    parameter int MAX_VALUE    = 20
) (
    input  logic       CLOCK_50,
    input  logic       KEY0,
    input  logic [6:0] SEG_IN,
    input  logic       SEG_DIG,
    input  logic       SEG_VLD,
    input  logic       ERR_CLR,
    output logic [3:0] BCD_ONES,
    output logic [3:0] BCD_TENS,
    output logic [6:0] VALUE,
    output logic       VALUE_VLD,
    output logic       SEG_ERR,
    output logic       RANGE_ERR
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_SCANS);
    localparam logic [6:0] VAL_MAX = 7'(MAX_VALUE);

    scan_state_t state, state_nxt;
    logic [3:0]  pend_u, cand_t, cand_u, cnt, cnt_nxt;
    logic [3:0]  dec_bcd;
    logic        dec_illegal;
    logic        sample_err, load_units, scan_done, pair_match, accept;
    logic [6:0]  pair_value;

    seg7_to_bcd u_dec (
        .seg     (SEG_IN),
        .is_tens (SEG_DIG),
        .bcd     (dec_bcd),
        .illegal (dec_illegal)
    );

    assign sample_err = SEG_VLD & dec_illegal;
    assign load_units = SEG_VLD & ~dec_illegal & (SEG_DIG == DIG_UNITS);

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) state <= WAIT_U;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        scan_done = 1'b0;
        if (SEG_VLD) begin
            if (dec_illegal) begin
                state_nxt = WAIT_U;
            end else begin
                case (state)
                    WAIT_U: if (SEG_DIG == DIG_UNITS) state_nxt = WAIT_T;
                    WAIT_T: if (SEG_DIG == DIG_TENS) begin
                        state_nxt = WAIT_U;
                        scan_done = 1'b1;
                    end
                    default: state_nxt = WAIT_U;
                endcase
            end
        end
    end

    assign pair_match = (dec_bcd == cand_t) && (pend_u == cand_u);
    assign cnt_nxt    = pair_match ? ((cnt == CNT_MAX) ? cnt : cnt + 4'd1) : 4'd1;
    // acceptance fires only on the scan that brings the count up to the threshold
    assign accept     = scan_done && (cnt_nxt == CNT_MAX) && !(pair_match && (cnt == CNT_MAX));
    assign pair_value = ({3'b000, dec_bcd} << 3) + ({3'b000, dec_bcd} << 1) + {3'b000, pend_u};

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            pend_u    <= 4'd0;
            cand_t    <= 4'd0;
            cand_u    <= 4'd0;
            cnt       <= 4'd0;
            BCD_ONES  <= 4'd0;
            BCD_TENS  <= 4'd0;
            VALUE     <= 7'd0;
            VALUE_VLD <= 1'b0;
            SEG_ERR   <= 1'b0;
            RANGE_ERR <= 1'b0;
        end else begin
            VALUE_VLD <= 1'b0;
            if (load_units) pend_u <= dec_bcd;
            if (sample_err) begin
                cnt <= 4'd0;
            end else if (scan_done) begin
                cnt <= cnt_nxt;
                if (!pair_match) begin
                    cand_t <= dec_bcd;
                    cand_u <= pend_u;
                end
            end
            if (accept) begin
                BCD_TENS  <= dec_bcd;
                BCD_ONES  <= pend_u;
                VALUE     <= pair_value;
                VALUE_VLD <= (pair_value != VALUE);
            end
            SEG_ERR   <= sample_err | (SEG_ERR & ~ERR_CLR);
            RANGE_ERR <= (accept && (pair_value > VAL_MAX)) | (RANGE_ERR & ~ERR_CLR);
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb/tb_seven_seg_capture.sv - randomized self-checking bench for seven_seg_capture
module tb_seven_seg_capture;

    localparam int STABLE = 3;
    localparam int MAXV   = 20;

    logic       CLOCK_50 = 1'b0;
    logic       KEY0     = 1'b0;
    logic [6:0] SEG_IN   = 7'b1111111;
    logic       SEG_DIG  = 1'b0;
    logic       SEG_VLD  = 1'b0;
    logic       ERR_CLR  = 1'b0;
    logic [3:0] BCD_ONES, BCD_TENS;
    logic [6:0] VALUE;
    logic       VALUE_VLD, SEG_ERR, RANGE_ERR;

    seven_seg_capture #(.STABLE_SCANS(STABLE), .MAX_VALUE(MAXV)) dut (
        .CLOCK_50  (CLOCK_50),
        .KEY0      (KEY0),
        .SEG_IN    (SEG_IN),
        .SEG_DIG   (SEG_DIG),
        .SEG_VLD   (SEG_VLD),
        .ERR_CLR   (ERR_CLR),
        .BCD_ONES  (BCD_ONES),
        .BCD_TENS  (BCD_TENS),
        .VALUE     (VALUE),
        .VALUE_VLD (VALUE_VLD),
        .SEG_ERR   (SEG_ERR),
        .RANGE_ERR (RANGE_ERR)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    localparam logic [6:0] BLANK = 7'b1111111;

    int total = 0;
    int bad   = 0;

    // reference model: digit history as plain integers
    bit m_have_units;
    int m_pend, m_cand, m_run, m_value, m_vld, m_seg_err, m_rng_err;

    task automatic check_eq(string tag, int obs, int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check_eq({tag, " value"}, int'(VALUE), m_value);
        check_eq({tag, " tens"}, int'(BCD_TENS), m_value / 10);
        check_eq({tag, " ones"}, int'(BCD_ONES), m_value % 10);
        check_eq({tag, " vld"}, int'(VALUE_VLD), m_vld);
        check_eq({tag, " seg_err"}, int'(SEG_ERR), m_seg_err);
        check_eq({tag, " range_err"}, int'(RANGE_ERR), m_rng_err);
    endtask

    function automatic int decode(logic [6:0] p, bit tens);
        if (p == BLANK) return tens ? 0 : -1;
        for (int i = 0; i < 10; i++) if (pat[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_have_units = 0;
        m_pend = 0; m_cand = 0; m_run = 0;
        m_value = 0; m_vld = 0; m_seg_err = 0; m_rng_err = 0;
    endtask

    task automatic model_sample(logic [6:0] p, bit tens, bit clr);
        int d, pair, prev_run;
        d = decode(p, tens);
        m_vld = 0;
        if (clr) begin m_seg_err = 0; m_rng_err = 0; end
        if (d < 0) begin
            m_seg_err = 1;
            m_have_units = 0;
            m_run = 0;
        end else if (!tens) begin
            m_pend = d;
            m_have_units = 1;
        end else if (m_have_units) begin
            m_have_units = 0;
            pair = d * 10 + m_pend;
            prev_run = m_run;
            if (pair == m_cand) m_run = (m_run < STABLE) ? m_run + 1 : STABLE;
            else begin m_cand = pair; m_run = 1; end
            if (m_run == STABLE && !(pair == m_cand && prev_run == STABLE)) begin
                if (pair != m_value) m_vld = 1;
                m_value = pair;
                if (pair > MAXV) m_rng_err = 1;
            end
        end
    endtask

    task automatic strobe(logic [6:0] p, bit tens, bit clr);
        @(negedge CLOCK_50);
        SEG_IN = p; SEG_DIG = tens; SEG_VLD = 1'b1; ERR_CLR = clr;
        model_sample(p, tens, clr);
        @(negedge CLOCK_50);
        SEG_VLD = 1'b0; ERR_CLR = 1'b0;
        SEG_IN = 7'($urandom);
        check_all("strobe");
        m_vld = 0;
    endtask

    task automatic scan(logic [6:0] tp, logic [6:0] up);
        strobe(up, 1'b0, 1'b0);
        strobe(tp, 1'b1, 1'b0);
    endtask

    task automatic clear_errs();
        @(negedge CLOCK_50);
        ERR_CLR = 1'b1;
        m_seg_err = 0; m_rng_err = 0;
        @(negedge CLOCK_50);
        ERR_CLR = 1'b0;
        check_eq("clr seg_err", int'(SEG_ERR), 0);
        check_eq("clr range_err", int'(RANGE_ERR), 0);
    endtask

    initial begin
        int vld_pulses;
        model_reset();
        repeat (3) @(negedge CLOCK_50);
        check_all("reset");
        KEY0 = 1'b1;

        // async reset mid-scan, then "39"
        repeat (3) scan(pat[0], pat[5]);
        strobe(pat[7], 1'b0, 1'b0);
        @(negedge CLOCK_50);
        #3 KEY0 = 1'b0;
        #1 model_reset();
        check_all("async_reset");
        @(negedge CLOCK_50);
        KEY0 = 1'b1;
        strobe(pat[3], 1'b1, 1'b0);
        repeat (3) scan(pat[3], pat[9]);
        check_eq("v39", int'(VALUE), 39);
        clear_errs();

        // stability: 12,12,13,13,13
        vld_pulses = 0;
        repeat (2) scan(pat[1], pat[2]);
        check_eq("no12", int'(VALUE), 39);
        repeat (3) scan(pat[1], pat[3]);
        check_eq("v13", int'(VALUE), 13);

        // blanked tens, then blank on units
        repeat (3) scan(BLANK, pat[4]);
        check_eq("v04", int'(VALUE), 4);
        strobe(BLANK, 1'b0, 1'b0);
        check_eq("blank_units_err", int'(SEG_ERR), 1);
        clear_errs();

        // illegal tens pattern between "07" scans
        repeat (2) scan(pat[0], pat[7]);
        strobe(pat[7], 1'b0, 1'b0);
        strobe(7'b0001000, 1'b1, 1'b0);
        repeat (2) scan(pat[0], pat[7]);
        check_eq("no07_yet", int'(VALUE), 4);
        scan(pat[0], pat[7]);
        check_eq("v07", int'(VALUE), 7);
        clear_errs();

        // ordering: leading tens ignored, units overwritten
        strobe(pat[2], 1'b1, 1'b0);
        strobe(pat[5], 1'b0, 1'b0);
        strobe(pat[8], 1'b0, 1'b0);
        strobe(pat[1], 1'b1, 1'b0);
        repeat (2) scan(pat[1], pat[8]);
        check_eq("v18", int'(VALUE), 18);

        // repeat "20": single pulse, no range error
        repeat (3) scan(pat[2], pat[0]);
        repeat (5) scan(pat[2], pat[0]);
        check_eq("v20", int'(VALUE), 20);
        check_eq("v20 range", int'(RANGE_ERR), 0);

        // new error wins over simultaneous clear
        strobe(7'b0110110, 1'b0, 1'b1);
        check_eq("err_wins", int'(SEG_ERR), 1);

        // randomized bursts of repeated scans with noise
        for (int b = 0; b < 80; b++) begin
            int t, u, reps;
            logic [6:0] tp;
            t = $urandom_range(0, 9);
            u = $urandom_range(0, 9);
            tp = (t == 0 && $urandom_range(0, 1) == 1) ? BLANK : pat[t];
            reps = $urandom_range(1, 5);
            for (int r = 0; r < reps; r++) begin
                if ($urandom_range(0, 11) == 0)
                    strobe(7'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
                if ($urandom_range(0, 7) == 0)
                    strobe(pat[$urandom_range(0, 9)], 1'b1, 1'b0);
                strobe(pat[u], 1'b0, 1'($urandom_range(0, 9) == 0));
                strobe(tp, 1'b1, 1'($urandom_range(0, 9) == 0));
                repeat ($urandom_range(0, 2)) begin
                    @(negedge CLOCK_50);
                    check_eq("idle vld", int'(VALUE_VLD), 0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
